lfsr_ext_counter: RTL and testbench
===================================

# lfsr_ext_counter

Parametrised successor to the fixed 64-bit high-speed counter. The low LFSR_BITS form a state-extended (de Bruijn) LFSR prescaler with 2^LFSR_BITS states. The upper WIDTH-LFSR_BITS bits form a binary counter that advances once per prescaler wrap. Added over the fixed version: synchronous clear, parallel load, terminal-value match, and overflow pulse. Sits wherever the design needs a fast free-running or gated event counter; Out is raw code (low field LFSR-coded, upper field binary).

## Interface
- WIDTH, 64: total counter width; must be greater than LFSR_BITS.
- LFSR_BITS, 4: prescaler width L; must be at least 3.
- TAPS, 4'b1100: Fibonacci tap mask over bits [L-1:0] of a maximal-length polynomial (default x^4+x^3+1); width L.

- Clk  in  1  rising-edge clock.
- nRst  in  1  asynchronous, active-low reset.
- CNT  in  1  count enable.
- Clr  in  1  synchronous clear.
- Load  in  1  synchronous parallel load.
- LoadVal  in  WIDTH  load value in raw code; any value is legal.
- TcVal  in  WIDTH  terminal value for Match, raw code.
- Out  out  WIDTH  counter state {upper, low}.
- Ovf  out  1  one-cycle overflow pulse.
- Match  out  1  registered compare flag.

## Operation
- Reset (nRst=0, asynchronous): Out=0, Ovf=0, Match=0. Outputs hold these values until the first rising edge after nRst is released.
- Priority per edge: Clr, then Load, then CNT.
  - Clr=1: Out<=0, Ovf<=0.
  - Load=1: Out<=LoadVal, Ovf<=0.
  - CNT=1: count.
  - Otherwise: hold, Ovf<=0.
- Low field s=Out[L-1:0], shift-left next state = {s[L-2:0], fb}.
  - fb = XOR over i of (s[i] & TAPS[i]), XOR (s[L-2:0]==0).
  - Sequence length is exactly 2^L; the all-zero state is inserted between {1,0...0} and {0...0,1}.
  - L=4 order: 0,1,2,4,9,3,6,D,A,5,B,7,F,E,C,8, then 0.
- TERM = {1'b1, (L-1)'b0}, i.e. 8 for L=4.
- Upper field U=Out[WIDTH-1:L]: U<=U+1 (mod 2^(WIDTH-L)) on the same edge that low goes TERM→0 with CNT=1.
- Carry path: the upper-field increment uses a registered low==TERM flag, not a combinational decode of low.
  - The flag is recomputed from the low field's next value on every edge, including Clr, Load and reset.
  - A load directly to TERM therefore carries correctly on the next count.
- Full-count wrap: U all ones, low==TERM, CNT=1 gives Out<=0 and Ovf<=1 for exactly the following cycle.
  - Back-to-back wraps are impossible; Ovf is never high for two consecutive cycles.
- Match <= (Out_next == TcVal) on every edge, so Match is high in the same cycle Out equals TcVal.
  - Reset value is 0 even when TcVal=0.
  - TcVal changes take effect at the next edge.
- Clr or Load asserted together with a wrap: the wrap is suppressed and Ovf=0.
- CNT low: the state is frozen, including the carry flag; resuming CNT continues the sequence without skipping or repeating a state.

## Timing
- One state step per edge; Out is fully registered, and count latency is 1 cycle.
- Ovf and Match are registered and aligned with the Out value they describe.
- No combinational path from any input to any output.
- Reset mid-count clears immediately, without waiting for a clock edge; the first count after release yields low=1.
- Critical path is bounded by the L-bit feedback plus the upper incrementer fed by a registered enable; it is independent of WIDTH for the low field.

## Test plan
- WIDTH=8, L=4, nRst low for 5 cycles, then CNT=1 -> Out steps 00,01,02,04,09,03,06,0D,0A,05,0B,07,0F,0E,0C,08, then 10 on the 16th edge.
- CNT=1 for 256 edges from reset -> Out=00 again; Ovf high only in the cycle Out returns to 00.
- CNT toggled 1/0 pseudo-randomly for 1000 cycles -> Out equals the reference model (sequence index advanced only on CNT=1 edges); Ovf count equals floor(enabled edges/256).
- Load=1 with LoadVal=8'hF8, then CNT=1 -> Out=F8, then 00 with Ovf=1. Load 8'h38 then count -> 40.
- Clr=1, Load=1 and CNT=1 together at Out=F8 -> Out=00, Ovf=0. Load=1 with CNT=1 -> Out=LoadVal.
- TcVal=8'h2D, count from reset -> Match high only in the cycle Out=2D. Async nRst pulse mid-cycle -> Out, Ovf and Match go 0 immediately.

Source files
------------

// File: rtl/lfsr_ext_counter.sv
// Event counter with a de Bruijn LFSR prescaler in the low bits and a binary upper field.
// The low field is LFSR-coded, so Out is raw code rather than a binary count.
module lfsr_ext_counter #(
  parameter int                   WIDTH     = 64,
  parameter int                   LFSR_BITS = 4,
  parameter logic [LFSR_BITS-1:0] TAPS      = 4'b1100
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             CNT,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] TcVal,
  output logic [WIDTH-1:0] Out,
  output logic             Ovf,
  output logic             Match
);

  localparam int UW = WIDTH - LFSR_BITS;
  localparam logic [LFSR_BITS-1:0] TERM = {1'b1, {(LFSR_BITS-1){1'b0}}};

  logic [LFSR_BITS-1:0] low;
  logic [LFSR_BITS-1:0] lowStep;
  logic [UW-1:0]        upper;
  logic [UW-1:0]        upperStep;
  logic                 feedback;
  logic                 termFlag;
  logic                 wrap;
  logic [WIDTH-1:0]     outNext;
  logic                 ovfNext;

  // Next-state selection: Clr beats Load beats CNT. The all-zero term in the
  // feedback splices state 0 in between TERM and 1, giving all 2^L states.
  always_comb begin
    low       = Out[LFSR_BITS-1:0];
    upper     = Out[WIDTH-1:LFSR_BITS];
    feedback  = (^(low & TAPS)) ^ (low[LFSR_BITS-2:0] == '0);
    lowStep   = {low[LFSR_BITS-2:0], feedback};
    upperStep = termFlag ? upper + 1'b1 : upper;
    wrap      = termFlag & (&upper);
    outNext   = Out;
    ovfNext   = 1'b0;
    if (Clr) begin
      outNext = '0;
    end else if (Load) begin
      outNext = LoadVal;
    end else if (CNT) begin
      outNext = {upperStep, lowStep};
      ovfNext = wrap;
    end
  end

  // termFlag is the registered "low == TERM" carry enable that keeps the
  // upper incrementer off the LFSR decode path; it tracks every state change.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      Out      <= '0;
      Ovf      <= 1'b0;
      Match    <= 1'b0;
      termFlag <= 1'b0;
    end else begin
      Out      <= outNext;
      Ovf      <= ovfNext;
      Match    <= (outNext == TcVal);
      termFlag <= (outNext[LFSR_BITS-1:0] == TERM);
    end
  end

endmodule

// File: tb/tb_lfsr_ext_counter.sv
// Scoreboard bench for lfsr_ext_counter (WIDTH=8, L=4): a count-index reference model
// pushes expected outputs, and a monitor pops and compares them every cycle.
module tb_lfsr_ext_counter;

  logic       Clk;
  logic       nRst;
  logic       CNT;
  logic       Clr;
  logic       Load;
  logic [7:0] LoadVal;
  logic [7:0] TcVal;
  logic [7:0] Out;
  logic       Ovf;
  logic       Match;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
    logic       match;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  fails = 0;
  int  total = 0;
  int  dutOvf = 0;
  int  enabled = 0;
  logic prevOvf = 1'b0;
  logic [3:0] seqTab [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                              4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  lfsr_ext_counter #(.WIDTH(8), .LFSR_BITS(4), .TAPS(4'b1100)) dut (
    .Clk(Clk), .nRst(nRst), .CNT(CNT), .Clr(Clr), .Load(Load),
    .LoadVal(LoadVal), .TcVal(TcVal), .Out(Out), .Ovf(Ovf), .Match(Match)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Raw code of a position in the full 256-step count sequence.
  function automatic logic [7:0] codeOf(input int t);
    logic [7:0] r;
    r[7:4] = 4'(t / 16);
    r[3:0] = seqTab[t % 16];
    return r;
  endfunction

  function automatic int indexOf(input logic [7:0] v);
    int idx = 0;
    for (int i = 0; i < 16; i++)
      if (seqTab[i] == v[3:0]) idx = i;
    return int'(v[7:4]) * 16 + idx;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cnt, input logic clr, input logic load,
                               input logic [7:0] lv, input logic [7:0] tv);
    expT e;
    @(negedge Clk);
    CNT = cnt; Clr = clr; Load = load; LoadVal = lv; TcVal = tv;
    e.ovf = 1'b0;
    if (clr) begin
      total = 0;
    end else if (load) begin
      total = indexOf(lv);
    end else if (cnt) begin
      e.ovf = (total == 255);
      total = (total + 1) % 256;
    end
    e.out   = codeOf(total);
    e.match = (e.out == tv);
    expQ.push_back(e);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 20) begin
      @(posedge Clk);
      #2;
      n++;
    end
    checkOutput("drain", 8'(expQ.size()), 8'h00);
  endtask

  // Monitor: one expected entry per clock edge while stimulus is flowing.
  initial begin
    expT e;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("out", Out, e.out);
        checkOutput("ovf", {7'b0, Ovf}, {7'b0, e.ovf});
        checkOutput("match", {7'b0, Match}, {7'b0, e.match});
        checkOutput("ovfTwice", {7'b0, prevOvf & Ovf}, 8'h00);
        prevOvf = Ovf;
        if (Ovf) dutOvf++;
      end
    end
  end

  initial begin
    logic [7:0] lv;
    logic [7:0] tv;
    int r;
    nRst = 1'b0; CNT = 1'b0; Clr = 1'b0; Load = 1'b0; LoadVal = 8'h00; TcVal = 8'h00;
    repeat (5) begin
      @(negedge Clk);
      checkOutput("resetOut", Out, 8'h00);
      checkOutput("resetOvf", {7'b0, Ovf}, 8'h00);
      checkOutput("resetMatch", {7'b0, Match}, 8'h00);
    end
    @(posedge Clk);
    #3 nRst = 1'b1;

    // Full sweep from reset with a terminal value inside the sequence.
    repeat (256) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h2D);
    waitDrain();

    // Gated counting from a cleared state; overflow count must follow enabled edges.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h2D);
    waitDrain();
    dutOvf = 0;
    enabled = 0;
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 1));
      applyStimulus(r[0], 1'b0, 1'b0, 8'h00, 8'h2D);
      enabled += r;
    end
    waitDrain();
    checkOutput("ovfCount", 8'(dutOvf), 8'(enabled / 256));

    // Directed loads, wrap from F8, carry from a loaded TERM, and priority cases.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF8, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h38, 8'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h40);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF8, 8'h40);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 8'h40);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA7, 8'hA7);
    applyStimulus(0, 0, 0, 8'h00, 8'hA7);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'hA7);
    waitDrain();

    // Random mix of clear, load, gating and terminal-value changes.
    tv = 8'h00;
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 15));
      lv = 8'($urandom);
      if ($urandom_range(0, 1) == 1) lv[3:0] = 4'h8;
      if (r == 2) tv = 8'($urandom);
      if (r == 3) tv = codeOf((total + 1) % 256);
      applyStimulus(1'($urandom_range(0, 1)), r == 0, r == 1, lv, tv);
    end
    waitDrain();

    // Asynchronous reset mid-cycle must clear outputs without a clock edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF8, 8'hF8);
    @(posedge Clk);
    #3 nRst = 1'b0;
    #1;
    checkOutput("asyncOut", Out, 8'h00);
    checkOutput("asyncOvf", {7'b0, Ovf}, 8'h00);
    checkOutput("asyncMatch", {7'b0, Match}, 8'h00);
    total = 0;
    repeat (2) @(posedge Clk);
    #3 nRst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
